// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Clock cycles per serial bit for a given system clock and line rate.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    // Expected parity bit for a data byte: even parity when odd=0, odd parity when odd=1.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a push into a full FIFO
    // still succeeds when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Head byte is masked to zero while empty so the output reads 0 out of reset.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are live, and resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo_if.sv
// UART 8N1 receiver with a receive FIFO drained over a valid/ready pop port.
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit (adds the i_parity_odd input).
module uart_rx_fifo_if #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 1_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    input  logic       i_err_clr,
`ifdef UART_RX_PARITY_EN
    input  logic       i_parity_odd,
`endif
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err
);

    import uart_rx_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic [1:0]           sync_fill;
    logic                 armed;

    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 bit_tick;

    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 frame_set;
    logic                 overrun_set;
    logic                 frame_err;
    logic                 overrun;

    // Two-flop synchronizer on the serial input; sync_fill marks when rx_s
    // holds a real line sample rather than the reset value.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its source, which makes rx_meta -> rx_s a true
    // two-stage chain instead of collapsing into one flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= i_uart_rx;
            rx_s      <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Arm start detection once the line has genuinely been seen idle; the
    // reset value of the sync flops is not trusted, so a line held low through
    // reset release is ignored until it goes high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) armed <= 1'b0;
        else if (sync_fill[1] && rx_s) armed <= 1'b1;
    end

    // Receive FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
        end
    end

    assign bit_tick = (cnt == CNT_LAST);

    // Next-state logic: start validation at mid start bit, then one sample per
    // bit tick (mid bit) for data, optional parity and stop.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        idx_next    = idx;
        shreg_next  = shreg;
        fifo_push   = 1'b0;
        frame_set   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (armed && !rx_s) state_next = START;
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        idx_next   = '0;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                cnt_next = bit_tick ? '0 : cnt + 1'b1;
                if (bit_tick) begin
                    shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
                    idx_next   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                cnt_next = bit_tick ? '0 : cnt + 1'b1;
                if (bit_tick) state_next = STOP;
            end
            STOP: begin
                cnt_next = bit_tick ? '0 : cnt + 1'b1;
                if (bit_tick) begin
                    state_next = IDLE;
                    if (rx_s) fifo_push = 1'b1;
                    else      frame_set = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    uart_rx_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (shreg),
        .pop       (i_ready),
        .head_data (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_valid     = ~fifo_empty;
    assign overrun_set = fifo_push & fifo_full & ~(i_ready & ~fifo_empty);

    // Sticky error flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_set   | (frame_err & ~i_err_clr);
            overrun   <= overrun_set | (overrun   & ~i_err_clr);
        end
    end

    assign o_frame_err = frame_err;
    assign o_overrun   = overrun;

`ifdef UART_RX_PARITY_EN
    logic parity_set;
    logic parity_err;

    assign parity_set = (state == PARITY) && bit_tick &&
                        (rx_s != parity_bit(shreg, i_parity_odd));

    // Sticky parity flag; the byte itself is still pushed if the stop bit is good.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) parity_err <= 1'b0;
        else         parity_err <= parity_set | (parity_err & ~i_err_clr);
    end

    assign o_parity_err = parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_if.sv
// Self-checking bench for uart_rx_fifo_if (CLKS_PER_BIT=10, FIFO_DEPTH=4).
// Bytes expected out of the FIFO are queued when their frame is driven and
// compared whenever the DUT completes a valid/ready pop.
`timescale 1ns/1ps
module tb_uart_rx_fifo_if;

    localparam int BIT_CLKS = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       i_uart_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       i_err_clr;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_parity_err;
`ifdef UART_RX_PARITY_EN
    logic       i_parity_odd;
    logic       par_bad;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo_if #(
        .CLK_FREQ_HZ (10_000_000),
        .BAUD_RATE   (1_000_000),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_uart_rx    (i_uart_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .i_err_clr    (i_err_clr),
`ifdef UART_RX_PARITY_EN
        .i_parity_odd (i_parity_odd),
`endif
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_parity_err (o_parity_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every completed pop must match the oldest expected byte.
    always @(negedge clk) begin
        if (resetn && o_valid && i_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("pop_data", o_data, exp_q.pop_front());
        end
    end

    task automatic drive_bit(input logic b);
        i_uart_rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting just after a posedge. The stop bit is driven
    // on posedge P0 (+1); the DUT samples it mid-bit and pushes on P0+8.
    // lat_chk: o_valid low before that edge, high right after it.
    // pop_at_stop: i_ready high for exactly the push cycle.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit, input bit expect_push,
                             input bit lat_chk, input bit pop_at_stop);
        if (expect_push) exp_q.push_back(data);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ i_parity_odd ^ par_bad);
`endif
        i_uart_rx = stop_bit;
        for (int c = 0; c < BIT_CLKS; c++) begin
            @(posedge clk);
            #1;
            if (pop_at_stop && c == 6) i_ready = 1'b1;
            if (pop_at_stop && c == 7) i_ready = 1'b0;
            if (lat_chk && c == 6) begin
                @(negedge clk);
                check("lat_before_push", o_valid, 0);
            end
            if (lat_chk && c == 7) begin
                @(negedge clk);
                check("lat_after_push", o_valid, 1);
            end
        end
        i_uart_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pop everything with a bounded wait, then require FIFO and scoreboard empty.
    task automatic drain(input string tag);
        i_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!o_valid) break;
        end
        check({tag, "_empty"}, o_valid, 0);
        check({tag, "_sb_left"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        i_err_clr = 1'b1;
        idle(1);
        i_err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        i_uart_rx = 1'b1;
        i_ready   = 1'b0;
        i_err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
        i_parity_odd = 1'b0;
        par_bad      = 1'b0;
`endif
        idle(3);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 8'h00);
        check("rst_frame", o_frame_err, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_parity", o_parity_err, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(20);

        // 1: two back-to-back frames with exact push latency.
        i_ready = 1'b1;
        send_byte(8'h55, 1'b1, 1, 1, 0);
        send_byte(8'hA3, 1'b1, 1, 1, 0);
        idle(20);
        drain("t1");
        check("t1_frame", o_frame_err, 0);
        check("t1_overrun", o_overrun, 0);
        check("t1_parity", o_parity_err, 0);

        // 2: short glitch is rejected; receiver still takes the next frame.
        i_uart_rx = 1'b0;
        idle(3);
        i_uart_rx = 1'b1;
        idle(30);
        @(negedge clk);
        check("t2_valid", o_valid, 0);
        check("t2_frame", o_frame_err, 0);
        idle(1);
        send_byte(8'h96, 1'b1, 1, 0, 0);
        idle(10);
        drain("t2");

        // 3: low stop bit -> frame error, byte discarded, flag clears.
        send_byte(8'h3C, 1'b0, 0, 0, 0);
        idle(20);
        @(negedge clk);
        check("t3_frame_set", o_frame_err, 1);
        check("t3_valid", o_valid, 0);
        pulse_clear();
        check("t3_frame_clr", o_frame_err, 0);
        idle(1);

        // 4: overflow with no pops; first four bytes survive in order.
        i_ready = 1'b0;
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, b <= 4, 0, 0);
        idle(5);
        @(negedge clk);
        check("t4_valid", o_valid, 1);
        check("t4_overrun", o_overrun, 1);
        check("t4_head", o_data, 8'h01);
        idle(1);
        drain("t4");
        pulse_clear();
        check("t4_overrun_clr", o_overrun, 0);
        idle(1);

        // 5: full FIFO with a pop in the push cycle -> no overrun, 5th byte kept.
        i_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b), 1'b1, 1, 0, 0);
        send_byte(8'h15, 1'b1, 1, 0, 1);
        idle(5);
        @(negedge clk);
        check("t5_overrun", o_overrun, 0);
        check("t5_head", o_data, 8'h12);
        idle(1);
        drain("t5");

        // 6: reset mid-frame with line low; flushes FIFO, low line ignored.
        i_ready = 1'b0;
        send_byte(8'h42, 1'b1, 0, 0, 0);
        idle(5);
        @(negedge clk);
        check("t6_prefill", o_valid, 1);
        idle(1);
        i_uart_rx = 1'b0;
        idle(40);
        resetn = 1'b0;
        idle(3);
        resetn = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_data", o_data, 8'h00);
        idle(30);
        i_uart_rx = 1'b1;
        idle(20);
        i_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_bad = 1'b1;
`endif
        send_byte(8'h7E, 1'b1, 1, 0, 0);
        idle(10);
        drain("t6");
        check("t6_frame", o_frame_err, 0);
        check("t6_overrun", o_overrun, 0);
`ifdef UART_RX_PARITY_EN
        check("t6_parity_set", o_parity_err, 1);
        par_bad = 1'b0;
`else
        check("t6_parity", o_parity_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
